hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core. It keeps a shadow copy of the register-use metadata for the D, E, M and W stages. From that it drives the stall and flush controls of the F/D and D/E pipeline registers and the execute-stage operand forwarding selects. It also freezes the pipe while data memory is not ready and counts stall cycles for performance monitoring.

---
 rtl/hazard_ctrl_if.sv | 28 ++
 rtl/hazard_ctrl.sv | 57 +++++
 tb/tb_hazard_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode metadata in, stall/flush/forward controls out
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] Rs1_d;
  logic [4:0] Rs2_d;
  logic [4:0] Rd_d;
  logic RegWrite_d;
  logic Load_d;
  logic MemAcc_d;
  logic PcSrc_e;
  logic Mem_ready_m;
  logic Stall_f;
  logic Stall_d;
  logic Stall_e;
  logic Stall_m;
  logic Flush_d;
  logic Flush_e;
  logic [1:0] Fwd_a_e;
  logic [1:0] Fwd_b_e;
  logic [CNT_W-1:0] Stall_cnt;
  modport master (
    output Rs1_d, Rs2_d, Rd_d, RegWrite_d, Load_d, MemAcc_d, PcSrc_e, Mem_ready_m,
    input Stall_f, Stall_d, Stall_e, Stall_m, Flush_d, Flush_e, Fwd_a_e, Fwd_b_e, Stall_cnt
  );
  modport slave (
    input Rs1_d, Rs2_d, Rd_d, RegWrite_d, Load_d, MemAcc_d, PcSrc_e, Mem_ready_m,
    output Stall_f, Stall_d, Stall_e, Stall_m, Flush_d, Flush_e, Fwd_a_e, Fwd_b_e, Stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: shadow-slot hazard detection, stall/flush control and E-stage forwarding
module hazard_ctrl #(parameter int CNT_W = 16) (
  input logic Clk,
  input logic Clear,
  hazard_ctrl_if.slave bus
);
  logic d_v, e_v, e_rw, e_ld, e_ma, m_v, m_rw, m_ma, w_v, w_rw;
  logic [4:0] e_rd, e_rs1, e_rs2, m_rd, w_rd;
  logic [CNT_W-1:0] cnt;
  logic mem_stall, lu, stall_f, m_ok, w_ok;
  always_comb begin
    mem_stall = m_v & m_ma & ~bus.Mem_ready_m;
    lu = d_v & e_v & e_ld & (e_rd != 5'd0) & (e_rd == bus.Rs1_d | e_rd == bus.Rs2_d);
    stall_f = ~Clear & (mem_stall | (~bus.PcSrc_e & lu));
    m_ok = e_v & m_v & m_rw & (m_rd != 5'd0);
    w_ok = e_v & w_v & w_rw & (w_rd != 5'd0);
    bus.Stall_f = stall_f;
    bus.Stall_d = stall_f;
    bus.Stall_e = ~Clear & mem_stall;
    bus.Stall_m = ~Clear & mem_stall;
    bus.Flush_d = Clear | (~mem_stall & bus.PcSrc_e);
    bus.Flush_e = Clear | (~mem_stall & (bus.PcSrc_e | lu));
    bus.Fwd_a_e = Clear ? 2'b00 : (m_ok & m_rd == e_rs1) ? 2'b10 : (w_ok & w_rd == e_rs1) ? 2'b01 : 2'b00;
    bus.Fwd_b_e = Clear ? 2'b00 : (m_ok & m_rd == e_rs2) ? 2'b10 : (w_ok & w_rd == e_rs2) ? 2'b01 : 2'b00;
    bus.Stall_cnt = cnt;
  end
  always_ff @(posedge Clk) begin
    if (Clear) begin
      d_v <= 1'b0;
      e_v <= 1'b0;
      m_v <= 1'b0;
      w_v <= 1'b0;
      cnt <= '0;
    end else begin
      if (stall_f && !(&cnt)) cnt <= cnt + CNT_W'(1);
      if (mem_stall) w_v <= 1'b0;
      else begin
        w_v <= m_v;
        w_rd <= m_rd;
        w_rw <= m_rw;
        m_v <= e_v;
        m_rd <= e_rd;
        m_rw <= e_rw;
        m_ma <= e_ma;
        // squashed or stalled decode enters E as a bubble; its fields are don't-care
        e_v <= d_v & ~bus.PcSrc_e & ~lu;
        e_rd <= bus.Rd_d;
        e_rw <= bus.RegWrite_d;
        e_ld <= bus.Load_d;
        e_ma <= bus.MemAcc_d;
        e_rs1 <= bus.Rs1_d;
        e_rs2 <= bus.Rs2_d;
        d_v <= bus.PcSrc_e ? 1'b0 : lu ? d_v : 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed hazard scenarios with hand-computed expectations
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic clear = 1'b1;
  int checks = 0;
  int errors = 0;
  hazard_ctrl_if #(.CNT_W(4)) bus();
  hazard_ctrl #(.CNT_W(4)) dut (.Clk(clk), .Clear(clear), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                   input logic rw, input logic ld, input logic ma);
    bus.Rs1_d = rs1;
    bus.Rs2_d = rs2;
    bus.Rd_d = rd;
    bus.RegWrite_d = rw;
    bus.Load_d = ld;
    bus.MemAcc_d = ma;
  endtask
  task automatic nop();
    d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    nop();
    bus.PcSrc_e = 1'b0;
    bus.Mem_ready_m = 1'b1;
    tick();
    tick();
    chk("rst_flush_d", 16'(bus.Flush_d), 16'd1);
    chk("rst_flush_e", 16'(bus.Flush_e), 16'd1);
    chk("rst_stalls", 16'({bus.Stall_f, bus.Stall_d, bus.Stall_e, bus.Stall_m}), 16'd0);
    clear = 1'b0;
    #1;
    chk("rst_cnt", 16'(bus.Stall_cnt), 16'd0);
    chk("rst_flush_off", 16'({bus.Flush_d, bus.Flush_e}), 16'd0);
    tick();
    d(5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    d(5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    #1;
    chk("alu_fwd_a", 16'(bus.Fwd_a_e), 16'h2);
    chk("alu_fwd_b", 16'(bus.Fwd_b_e), 16'h2);
    chk("alu_nostall", 16'(bus.Stall_f), 16'd0);
    tick();
    chk("alu_cnt", 16'(bus.Stall_cnt), 16'd0);
    d(5'd7, 5'd8, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    d(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    #1;
    chk("w_fwd_a", 16'(bus.Fwd_a_e), 16'h1);
    chk("w_fwd_b", 16'(bus.Fwd_b_e), 16'h0);
    tick();
    d(5'd2, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1);
    tick();
    d(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_stall", 16'({bus.Stall_f, bus.Stall_d, bus.Flush_e}), 16'h7);
    chk("lu_noflush_d", 16'({bus.Flush_d, bus.Stall_e, bus.Stall_m}), 16'h0);
    tick();
    chk("lu_one_cycle", 16'({bus.Stall_f, bus.Flush_e}), 16'h0);
    chk("lu_cnt", 16'(bus.Stall_cnt), 16'd1);
    tick();
    nop();
    #1;
    chk("lu_fwd_a", 16'(bus.Fwd_a_e), 16'h1);
    chk("lu_fwd_b", 16'(bus.Fwd_b_e), 16'h0);
    tick();
    d(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1);
    tick();
    d(5'd9, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0);
    bus.PcSrc_e = 1'b1;
    #1;
    chk("br_flush", 16'({bus.Flush_d, bus.Flush_e}), 16'h3);
    chk("br_nostall", 16'({bus.Stall_f, bus.Stall_d}), 16'h0);
    tick();
    bus.PcSrc_e = 1'b0;
    d(5'd9, 5'd9, 5'd11, 1'b1, 1'b0, 1'b0);
    #1;
    chk("br_sq1_fwd", 16'({bus.Fwd_a_e, bus.Fwd_b_e}), 16'h0);
    tick();
    nop();
    #1;
    chk("br_sq2_fwd", 16'({bus.Fwd_a_e, bus.Fwd_b_e}), 16'h0);
    chk("br_cnt", 16'(bus.Stall_cnt), 16'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    d(5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b1);
    tick();
    nop();
    tick();
    bus.Mem_ready_m = 1'b0;
    #1;
    chk("mw_stalls", 16'({bus.Stall_f, bus.Stall_d, bus.Stall_e, bus.Stall_m}), 16'hf);
    chk("mw_cnt0", 16'(bus.Stall_cnt), 16'd0);
    tick();
    bus.PcSrc_e = 1'b1;
    #1;
    chk("mw_br_deferred", 16'({bus.Flush_d, bus.Flush_e}), 16'h0);
    chk("mw_stall2", 16'(bus.Stall_f), 16'd1);
    tick();
    bus.PcSrc_e = 1'b0;
    #1;
    chk("mw_stall3", 16'(bus.Stall_m), 16'd1);
    tick();
    bus.Mem_ready_m = 1'b1;
    bus.PcSrc_e = 1'b1;
    #1;
    chk("mw_resume", 16'({bus.Stall_f, bus.Stall_d, bus.Stall_e, bus.Stall_m}), 16'h0);
    chk("mw_br_now", 16'(bus.Flush_d), 16'd1);
    chk("mw_cnt3", 16'(bus.Stall_cnt), 16'd3);
    tick();
    bus.PcSrc_e = 1'b0;
    chk("mw_cnt_hold", 16'(bus.Stall_cnt), 16'd3);
    tick();
    d(5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    d(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    #1;
    chk("x0_fwd", 16'({bus.Fwd_a_e, bus.Fwd_b_e}), 16'h0);
    tick();
    d(5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 1'b1);
    tick();
    d(5'd13, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
    #1;
    chk("cl_pre_stall", 16'(bus.Stall_f), 16'd1);
    clear = 1'b1;
    #1;
    chk("cl_stall_off", 16'({bus.Stall_f, bus.Stall_d}), 16'h0);
    chk("cl_flush_on", 16'({bus.Flush_d, bus.Flush_e}), 16'h3);
    tick();
    clear = 1'b0;
    #1;
    chk("cl_after_stall", 16'({bus.Stall_f, bus.Stall_d, bus.Flush_e}), 16'h0);
    chk("cl_after_fwd", 16'({bus.Fwd_a_e, bus.Fwd_b_e}), 16'h0);
    chk("cl_after_cnt", 16'(bus.Stall_cnt), 16'd0);
    nop();
    tick();
    d(5'd0, 5'd0, 5'd15, 1'b1, 1'b1, 1'b1);
    tick();
    nop();
    tick();
    bus.Mem_ready_m = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    chk("sat_cnt", 16'(bus.Stall_cnt), 16'hf);
    chk("sat_stall", 16'(bus.Stall_f), 16'd1);
    tick();
    chk("sat_hold", 16'(bus.Stall_cnt), 16'hf);
    bus.Mem_ready_m = 1'b1;
    #1;
    chk("sat_release", 16'(bus.Stall_m), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
